// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding and stall-counter helpers for pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Single-entry skid register catching a payload that arrives
//               while the main output register is back-pressured.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 18,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             unload,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (unload) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end
    end

    assign skid_valid = r_valid;
    assign skid_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : Valid/ready pipeline register with flush and a saturating
//               back-pressure counter. Define PIPE_STAGE_SKID_EN to add a skid
//               entry that registers in_ready for full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 18,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t                 r_state;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_accept;
    logic                   w_consume;

    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_skid_load;
    logic             w_skid_unload;

    // Ready depends only on the registered skid occupancy, never on out_ready.
    assign in_ready      = !rst && !w_skid_valid;
    assign w_skid_load   = w_accept && (r_state == FULL) && !out_ready;
    assign w_skid_unload = (r_state == SKID) && out_ready;

    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (w_skid_load),
        .load_data  (in_data),
        .unload     (w_skid_unload),
        .skid_valid (w_skid_valid),
        .skid_data  (w_skid_data)
    );
`else
    assign in_ready = !rst && (!r_out_valid || out_ready);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_VALUE;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_VALUE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        if (w_accept) begin
                            r_out_data <= in_data;
                        end else begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                            r_out_data  <= NOP_VALUE;
                        end
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (w_accept) begin
                        r_state <= SKID;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (w_consume) begin
                        r_state    <= FULL;
                        r_out_data <= w_skid_data;
                    end
                end
`endif
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_out_data  <= NOP_VALUE;
                end
            endcase
        end
    end

    // Flush cycles are not counted, and flush never clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !flush) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage
// Description : Scoreboard bench for pipe_stage, with and without PIPE_STAGE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage;

    localparam int WIDTH = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [15:0]      stall_cnt;

    logic [WIDTH-1:0] sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    pipe_stage #(
        .WIDTH     (WIDTH),
        .NOP_VALUE ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 18'h12345; out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_basic_pass();
        do_reset();
        in_valid = 1'b1; in_data = 18'h0ABCD; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        if (in_valid && in_ready) sb.push_back(in_data);
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL basic_out_data: nothing accepted, got %h", out_data); end
        else if (out_data !== sb[0]) begin n_fail++; $display("FAIL basic_out_data: got %h expected %h", out_data, sb[0]); end
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL basic_drain_data: got %h expected 0", out_data); end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int got  = 0;
        do_reset();
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 3);
            in_data   = WIDTH'(sent + 1);
            #1;
            if (cyc == 2) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stalled: got %b expected 0", in_ready); end
            end
            if (cyc == 5) begin
                n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 4", stall_cnt); end
                n_checks++; if (out_data !== 18'h00001) begin n_fail++; $display("FAIL bp_hold_data: got %h expected 00001", out_data); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_order: unexpected output %h", out_data); end
                else if (out_data !== sb[0]) begin n_fail++; $display("FAIL bp_order: got %h expected %h", out_data, sb[0]); end
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); sent++; end
            @(negedge clk);
        end
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL bp_count: got %0d outputs expected 3", got); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 18'h00010; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 18'h00020; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL flush_data: got %h expected 0", out_data); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_stall_kept: got %0d expected 1", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_delivery: got valid %b data %h expected 0", out_valid, out_data); end
        end
        sb.delete();
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_data = 18'h15555; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (65534) @(negedge clk);
        #1;
        n_checks++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_edge_minus1: got %h expected fffe", stall_cnt); end
        @(negedge clk);
        #1;
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", stall_cnt); end
        repeat (70000 - 65535) @(negedge clk);
        #1;
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 18'h15555) begin n_fail++; $display("FAIL sat_payload_hold: got %b/%h expected 1/15555", out_valid, out_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1; in_data = 18'h3FFFF; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (out_data !== 18'h3FFFF || stall_cnt !== 16'd3) begin n_fail++; $display("FAIL areset_pre: got %h/%0d expected 3ffff/3", out_data, stall_cnt); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL areset_data: got %h expected 0", out_data); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL areset_stall: got %h expected 0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_ready_indep();
        logic rdy_lo;
        logic rdy_hi;
        do_reset();
        in_valid = 1'b1; in_data = 18'h00777; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rdy_lo = in_ready;
        out_ready = 1'b1;
        #1;
        rdy_hi = in_ready;
`ifdef PIPE_STAGE_SKID_EN
        n_checks++; if (rdy_lo !== 1'b1 || rdy_hi !== 1'b1) begin n_fail++; $display("FAIL ready_indep: got %b/%b expected 1/1", rdy_lo, rdy_hi); end
`else
        n_checks++; if (rdy_lo !== 1'b0 || rdy_hi !== 1'b1) begin n_fail++; $display("FAIL ready_comb: got %b/%b expected 0/1", rdy_lo, rdy_hi); end
`endif
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (sent < 8);
            in_data  = WIDTH'($urandom);
            #1;
            if (in_valid) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_order: unexpected output %h", out_data); end
                else if (out_data !== sb[0]) begin n_fail++; $display("FAIL b2b_order: got %h expected %h", out_data, sb[0]); end
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); sent++; end
            @(negedge clk);
        end
        n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d outputs expected 8", got); end
    endtask

    task automatic test_random();
        logic [15:0] model_stall = 16'h0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            #1;
            n_checks++; if (stall_cnt !== model_stall) begin n_fail++; $display("FAIL rnd_stall: cycle %0d got %0d expected %0d", cyc, stall_cnt, model_stall); end
            if (!out_valid) begin
                n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rnd_nop: cycle %0d got %h expected 0", cyc, out_data); end
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin n_fail++; $display("FAIL rnd_order: cycle %0d unexpected output %h", cyc, out_data); end
                    else if (out_data !== sb[0]) begin n_fail++; $display("FAIL rnd_order: cycle %0d got %h expected %h", cyc, out_data, sb[0]); end
                    if (sb.size() != 0) void'(sb.pop_front());
                end
                if (in_valid && in_ready) sb.push_back(in_data);
                if (out_valid && !out_ready && model_stall != 16'hFFFF) model_stall++;
            end
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        test_reset();
        test_basic_pass();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_ready_indep();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
